// File: rtl/loader_pkg.sv
// ============================================================================
//  loader_pkg
//  Shared types and constants for the boot-time instruction loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } loader_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          HDR_BYTES = 2;

endpackage : loader_pkg

`default_nettype wire

// File: rtl/instr_loader_if.sv
// ============================================================================
//  instr_loader_if
//  Byte-stream valid/ready handshake feeding the instruction loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface instr_loader_if;

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );

endinterface : instr_loader_if

`default_nettype wire

// File: rtl/instr_loader_mem.sv
// ============================================================================
//  instr_mem
//  DEPTH x 32 instruction array: synchronous write, asynchronous read.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instr_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [ADDR_WIDTH-1:0] waddr,
    input  wire logic [31:0]           wdata,
    input  wire logic [ADDR_WIDTH-1:0] raddr,
    output      logic [31:0]           rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : instr_mem

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  instr_loader
//  Loads a length-prefixed little-endian word stream into the instruction
//  store and gates the core's enable. Optional trailing XOR checksum byte
//  is enabled by defining LOADER_CHECKSUM_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    instr_loader_if.slave              byte_if,
    input  wire logic                  reload,
    input  wire logic [ADDR_WIDTH-1:0] rom_address,
    output      logic [31:0]           rom_data,
    output      logic                  cpu_enable,
    output      logic                  load_done,
    output      logic                  load_error,
    output      logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [2:0] ST_HDR_LO = 3'(HDR_LO);
    localparam logic [2:0] ST_HDR_HI = 3'(HDR_HI);
    localparam logic [2:0] ST_DATA   = 3'(DATA);
    localparam logic [2:0] ST_CHECK  = 3'(CHECK);
    localparam logic [2:0] ST_RUN    = 3'(RUN);
    localparam logic [2:0] ST_ERROR  = 3'(ERROR);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_POST_DATA = ST_CHECK;
`else
    localparam logic [2:0] ST_POST_DATA = ST_RUN;
`endif

    logic [2:0]            r_state;
    logic [7:0]            r_hdr_lo;
    logic [ADDR_WIDTH:0]   r_n;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_shift;
    logic [ADDR_WIDTH:0]   r_word_count;

    logic                  w_accept;
    logic                  w_restart;
    logic [15:0]           w_hdr_n;
    logic [ADDR_WIDTH:0]   w_ptr_inc;
    logic                  w_mem_we;
    logic [31:0]           w_mem_wdata;
    logic [31:0]           w_mem_rdata;
    logic                  w_rd_hit;

    assign byte_if.byte_ready = (r_state == ST_HDR_LO) || (r_state == ST_HDR_HI) ||
                                (r_state == ST_DATA)   || (r_state == ST_CHECK);

    assign w_accept    = byte_if.byte_valid && byte_if.byte_ready;
    assign w_restart   = reload && ((r_state == ST_RUN) || (r_state == ST_ERROR));
    assign w_hdr_n     = {byte_if.byte_data, r_hdr_lo};
    assign w_ptr_inc   = {1'b0, r_ptr} + (ADDR_WIDTH+1)'(1);
    assign w_mem_wdata = {byte_if.byte_data, r_shift};
    // Reset gates the write so an aborted load never commits a partial word.
    assign w_mem_we    = rst && w_accept && (r_state == ST_DATA) && (r_byte_cnt == 2'd3);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_csum <= 8'h00;
        end else if (w_restart) begin
            r_csum <= 8'h00;
        end else if (w_accept && (r_state != ST_CHECK)) begin
            r_csum <= r_csum ^ byte_if.byte_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_HDR_LO;
            r_hdr_lo     <= 8'h00;
            r_n          <= '0;
            r_ptr        <= '0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'h0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_HDR_LO: begin
                    if (w_accept) begin
                        r_hdr_lo <= byte_if.byte_data;
                        r_state  <= ST_HDR_HI;
                    end
                end
                ST_HDR_HI: begin
                    if (w_accept) begin
                        r_ptr      <= '0;
                        r_byte_cnt <= 2'd0;
                        r_n        <= w_hdr_n[ADDR_WIDTH:0];
                        if (w_hdr_n > 16'(DEPTH)) begin
                            r_state <= ST_ERROR;
                        end else if (w_hdr_n == 16'h0000) begin
                            r_state <= ST_POST_DATA;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= {byte_if.byte_data, r_shift[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            r_ptr        <= r_ptr + 1'b1;
                            r_word_count <= w_ptr_inc;
                            if (w_ptr_inc == r_n) begin
                                r_state <= ST_POST_DATA;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept) begin
                        r_state <= (byte_if.byte_data == r_csum) ? ST_RUN : ST_ERROR;
                    end
                end
`endif
                ST_RUN, ST_ERROR: begin
                    if (reload) begin
                        r_state      <= ST_HDR_LO;
                        r_word_count <= '0;
                        r_ptr        <= '0;
                        r_byte_cnt   <= 2'd0;
                    end
                end
                default: begin
                    r_state <= ST_HDR_LO;
                end
            endcase
        end
    end

    instr_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_ptr),
        .wdata (w_mem_wdata),
        .raddr (rom_address),
        .rdata (w_mem_rdata)
    );

    // Words beyond the loaded image read as NOP so a stray fetch is harmless.
    assign w_rd_hit   = ({1'b0, rom_address} < r_word_count);
    assign rom_data   = w_rd_hit ? w_mem_rdata : NOP_INSTR;

    assign cpu_enable = (r_state == ST_RUN);
    assign load_done  = (r_state == ST_RUN);
    assign load_error = (r_state == ST_ERROR);
    assign word_count = r_word_count;

endmodule : instr_loader

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
//  tb_instr_loader
//  Randomized directed bench for instr_loader with a word-level image model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_loader;

    localparam int          ADDR_WIDTH = 8;
    localparam int          DEPTH      = 256;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic                  clk;
    logic                  rst;
    logic                  reload;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [31:0]           rom_data;
    logic                  cpu_enable;
    logic                  load_done;
    logic                  load_error;
    logic [ADDR_WIDTH:0]   word_count;

    instr_loader_if bif ();

    instr_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_if     (bif),
        .reload      (reload),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .cpu_enable  (cpu_enable),
        .load_done   (load_done),
        .load_error  (load_error),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_mem [DEPTH];
    int          exp_count = 0;
    logic [31:0] wq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        return (a < exp_count) ? exp_mem[a] : NOP;
    endfunction

    task automatic read_check(input int a);
        @(negedge clk);
        rom_address = a[ADDR_WIDTH-1:0];
        #1;
        check($sformatf("rom_data[%0d]", a), rom_data, model_read(a));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        bif.byte_data  = b;
        bif.byte_valid = 1'b1;
        while (!bif.byte_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check("byte_ready_wait", {31'd0, bif.byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'($urandom);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Builds the byte stream for an image, sends it, and checks the outcome.
    task automatic load_image(input int n, input logic [31:0] words[$],
                              input bit bad_csum, input int stall_at);
        logic [7:0] s [$];
        logic [7:0] cs;
        bit         err;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            foreach (words[i])
                for (int k = 0; k < 4; k++) s.push_back(8'(words[i] >> (8 * k)));
`ifdef LOADER_CHECKSUM_EN
            cs = 8'h00;
            foreach (s[i]) cs ^= s[i];
            if (bad_csum) cs ^= 8'h5A;
            s.push_back(cs);
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        err = (n > DEPTH) || bad_csum;
`else
        err = (n > DEPTH);
        cs  = {7'd0, bad_csum};
`endif
        foreach (s[i]) begin
            if (i == s.size() - 1) begin
                check("cpu_enable_before_last", {31'd0, cpu_enable}, 32'd0);
                check("load_error_before_last", {31'd0, load_error}, 32'd0);
            end
            send_byte(s[i]);
            if (i == stall_at) begin
                // reload outside RUN/ERROR must be ignored
                pulse_reload();
                repeat (9) @(posedge clk);
                #1;
            end
        end
        if (n <= DEPTH) begin
            foreach (words[i]) exp_mem[i] = words[i];
            exp_count = n;
        end else begin
            exp_count = 0;
        end
        check("cpu_enable_end", {31'd0, cpu_enable}, {31'd0, !err});
        check("load_done_end",  {31'd0, load_done},  {31'd0, !err});
        check("load_error_end", {31'd0, load_error}, {31'd0, err});
        check("byte_ready_end", {31'd0, bif.byte_ready}, 32'd0);
        check("word_count_end", {23'd0, word_count}, exp_count);
    endtask

    task automatic reload_and_check();
        pulse_reload();
        check("reload_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        check("reload_byte_ready", {31'd0, bif.byte_ready}, 32'd1);
        check("reload_word_count", {23'd0, word_count}, 32'd0);
        exp_count = 0;
    endtask

    task automatic random_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        rst            = 1'b0;
        reload         = 1'b0;
        rom_address    = '0;
        bif.byte_data  = 8'h00;
        bif.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", {31'd0, bif.byte_ready}, 32'd1);
        check("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        check("rst_load_done",  {31'd0, load_done},  32'd0);
        check("rst_load_error", {31'd0, load_error}, 32'd0);
        check("rst_word_count", {23'd0, word_count}, 32'd0);
        check("rst_rom_data",   rom_data, NOP);
        @(negedge clk);
        rst = 1'b1;

        // Reference image from the test plan
        wq.delete();
        wq.push_back(32'h0050_0513);
        wq.push_back(32'h0000_006F);
        load_image(2, wq, 1'b0, -1);
        read_check(0);
        read_check(1);
        read_check(5);
        check("plan_word0", model_read(0), 32'h0050_0513);

        // Reload from RUN replaces word 0
        reload_and_check();
        random_words(1);
        load_image(1, wq, 1'b0, -1);
        for (int a = 0; a < 3; a++) read_check(a);

        // Random images with random stalls
        for (int t = 0; t < 4; t++) begin
            reload_and_check();
            random_words($urandom_range(1, 12));
            load_image(wq.size(), wq, 1'b0, -1);
            for (int a = 0; a < wq.size() + 2; a++) read_check(a);
        end

        // Full array: largest legal header
        reload_and_check();
        random_words(DEPTH);
        load_image(DEPTH, wq, 1'b0, -1);
        for (int a = 0; a < DEPTH; a++) read_check(a);

        // Oversize header N = 257
        reload_and_check();
        wq.delete();
        load_image(257, wq, 1'b0, -1);
        read_check(0);

        // Empty image
        reload_and_check();
        wq.delete();
        load_image(0, wq, 1'b0, -1);
        read_check(0);
        read_check(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
        // Correct one-word image with a corrupted checksum byte
        reload_and_check();
        random_words(1);
        load_image(1, wq, 1'b1, -1);
        reload_and_check();
        check("csum_err_cleared", {31'd0, load_error}, 32'd0);
`endif

        // Stall of ten idle cycles mid-word, with an ignored reload inside it
        reload_and_check();
        random_words(3);
        load_image(3, wq, 1'b0, 7);
        for (int a = 0; a < 4; a++) read_check(a);

        // Reset after six data bytes aborts the load
        reload_and_check();
        random_words(2);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'(wq[i / 4] >> (8 * (i % 4))));
        exp_mem[0] = wq[0];
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_count = 0;
        check("abort_word_count", {23'd0, word_count}, 32'd0);
        check("abort_byte_ready", {31'd0, bif.byte_ready}, 32'd1);
        check("abort_load_done",  {31'd0, load_done},  32'd0);
        check("abort_load_error", {31'd0, load_error}, 32'd0);
        check("abort_rom_data",   rom_data, NOP);
        random_words(1);
        load_image(1, wq, 1'b0, -1);
        for (int a = 0; a < 3; a++) read_check(a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_loader

`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader and instruction store that sits directly upstream of the CPU core. It accepts a byte stream (from a UART receiver or a test bench) containing a word count and little-endian instruction words, and writes them into a 256×32 instruction array. It serves that array to the core's fetch port (`rom_address` → `rom_data`) and holds the core's `enable` low until a complete image has been loaded.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: width of `rom_address`.
- `DEPTH`, default 256: number of 32-bit words; must equal 2**ADDR_WIDTH.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous, active-low.
- `byte_data` in 8: incoming stream byte.
- `byte_valid` in 1: `byte_data` is valid this cycle.
- `byte_ready` out 1: the loader accepts a byte this cycle.
- `reload` in 1: single-cycle pulse that restarts loading from RUN or ERROR.
- `rom_address` in ADDR_WIDTH: word address driven by the core's fetch stage.
- `rom_data` out 32: instruction word at `rom_address`.
- `cpu_enable` out 1: drives the core's `enable`; high only in RUN.
- `load_done` out 1: high in RUN.
- `load_error` out 1: high in ERROR.
- `word_count` out ADDR_WIDTH+1: number of valid words loaded.

## Operation
- **Handshake.** A byte is accepted on any rising edge where `byte_valid && byte_ready`.
  - `byte_ready` is high in HDR_LO, HDR_HI, DATA and CHECK.
  - `byte_ready` is low in RUN and ERROR.
- **Stream format.**
  - Header N: 16 bits, low byte first.
  - Then N×4 data bytes. Each word is little-endian (byte 0 = bits 7:0).
  - Then one checksum byte, only when the checksum macro is defined.
- **States:**
  - HDR_LO: latch the low header byte, then go to HDR_HI.
  - HDR_HI: form N.
    - N > DEPTH: go to ERROR.
    - N == 0: go to CHECK if the checksum macro is defined, else RUN.
    - Otherwise go to DATA with the write pointer at 0.
  - DATA: assemble bytes into a 32-bit shift register using a 2-bit byte counter.
    - On the 4th accepted byte, write the word to `mem[ptr]`, increment `ptr`, and update `word_count` to `ptr+1`.
    - When `ptr+1 == N`, leave DATA for CHECK or RUN.
  - CHECK: compare the received byte against the running checksum. Match goes to RUN; mismatch goes to ERROR.
  - RUN: terminal state for normal operation.
  - ERROR: terminal state for a failed load.
  - From RUN or ERROR, `reload` goes to HDR_LO and clears `word_count`, `ptr`, the byte counter and the checksum. Array contents are not cleared.
- **Read port.** `rom_data` is a combinational read of `mem[rom_address]` when `rom_address < word_count`; otherwise it is 32'h00000013 (NOP).
- **Width rule.** `word_count` is ADDR_WIDTH+1 bits so that a full load of 256 words is representable.
- **`reload` outside RUN/ERROR** is ignored.

## Timing
- **Reset values** (`rst == 0` at a rising edge):
  - state = HDR_LO.
  - `byte_ready` = 1.
  - `cpu_enable`, `load_done` and `load_error` = 0.
  - `word_count` = 0, hence `rom_data` = NOP.
- **Reset during a load** aborts the load. No partial word is written.
- **Word visibility.** A word written on edge k is visible on `rom_data` from cycle k+1.
- **`cpu_enable` / `load_done`** are registered. They rise on the edge that accepts the final stream byte (the last data byte, header byte, or checksum byte).
- **`load_error`** rises on the edge that accepts the offending byte.
- **`reload` in RUN** drops `cpu_enable` on the same edge that samples it.
- **Stalls.** Gaps in `byte_valid` are allowed anywhere and have no timeout. State and the partial word are held.
- **Throughput** is one byte per cycle.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- **Defined:**
  - The checksum is the XOR of all header and data bytes.
  - The CHECK state exists and one trailing checksum byte is required.
  - A mismatch enters ERROR and `cpu_enable` stays 0.
- **Undefined:**
  - No CHECK state and no trailing checksum byte.
  - `load_error` is asserted only for N > DEPTH.

## Structure
- Package `loader_pkg`:
  - state enum (HDR_LO, HDR_HI, DATA, CHECK, RUN, ERROR);
  - `NOP_INSTR` = 32'h00000013;
  - `HDR_BYTES` = 2.
- Sub-module `instr_mem`: DEPTH×32 array with synchronous write and asynchronous read. The loader FSM owns the write port; the read port serves `rom_address`.

## Test plan
- **Normal load.** Stream 02 00, 13 05 50 00, 6F 00 00 00, with a checksum byte if `LOADER_CHECKSUM_EN` is defined.
  - `word_count` = 2.
  - `rom_address` 0 → 32'h00500513; `rom_address` 1 → 32'h0000006F; `rom_address` 5 → 32'h00000013.
  - `cpu_enable` rises on the edge accepting the final byte.
- **Oversize header.** Stream 01 01 (N = 257) → `load_error` = 1, `byte_ready` = 0, `cpu_enable` stays 0.
- **Checksum mismatch** (`LOADER_CHECKSUM_EN` defined). Correct 1-word image with a wrong final byte → ERROR. `reload` pulse → HDR_LO with `word_count` = 0.
- **Stalls and reset.** Drop `byte_valid` for 10 cycles mid-word → resumes with the correct word assembled. Assert `rst` = 0 after 6 data bytes → `word_count` = 0 and state = HDR_LO.
- **Empty image.** Stream 00 00 (plus checksum byte 00 if `LOADER_CHECKSUM_EN` is defined) → RUN with `word_count` = 0, and every address reads 32'h00000013.
- **Reload from RUN.** Pulse `reload` after a full load → `cpu_enable` = 0 on the next cycle; a new 1-word image replaces word 0 and `word_count` = 1.
